// File: rtl/snake_pkg.sv
// Shared types and helpers for the Snake direction input path.
package snake_pkg;

  // Committed / queued movement direction.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Bit positions of each button inside a player's 4-bit key group.
  localparam int KEY_LEFT  = 3;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_RIGHT = 0;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_key_debounce.sv
// One active-low button: 2-flop synchroniser, saturating stability counter
// and a single-cycle press pulse on the debounced released->pressed edge.
module snake_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic held,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the debounced state; flip on the last one.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = CNT_ZERO;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = CNT_ZERO;
        press_d  = ~sync2_q;
      end else begin
        cnt_d    = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Synchroniser, counter and edge flops; everything resets to "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= CNT_ZERO;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign held  = ~stable_q;
  assign press = press_q;

endmodule

// File: rtl/snake_dir_queue.sv
// Per-player direction input: debounced key presses are filtered against the
// last requested direction and queued, one entry committed per move_tick.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int   NUM_PLAYERS     = 1,
  parameter int   QUEUE_DEPTH     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter dir_t INIT_DIR        = DIR_LEFT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4*NUM_PLAYERS-1:0] keys,
  input  logic                     move_tick,
  input  logic                     clear,
  output logic [2*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   dir_changed,
  output logic [NUM_PLAYERS-1:0]   key_lock,
  output logic [NUM_PLAYERS-1:0]   overflow
);

  localparam int IW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(QUEUE_DEPTH - 1);

  logic [4*NUM_PLAYERS-1:0] held_s;
  logic [4*NUM_PLAYERS-1:0] press_s;

  for (genvar k = 0; k < 4*NUM_PLAYERS; k++) begin : g_key
    snake_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (keys[k]),
      .held    (held_s[k]),
      .press   (press_s[k])
    );
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    dir_t          mem_q [QUEUE_DEPTH];
    dir_t          mem_d [QUEUE_DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_t          dir_q, dir_d;
    logic          chg_q, chg_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    ev_s;
    logic          has_ev_s;
    dir_t          ev_dir_s;
    dir_t          ref_dir_s;
    logic [IW-1:0] tail_idx_s;
    logic [IW-1:0] wr_idx_s;
    logic          legal_s, pop_s, push_s, full_s;
    int            tail_i;
    int            wr_i;

    assign ev_s = press_s[4*p +: 4];

    // Reduce simultaneous press events to one, up > down > left > right.
    always_comb begin
      has_ev_s = 1'b1;
      ev_dir_s = DIR_UP;
      if (ev_s[KEY_UP]) begin
        ev_dir_s = DIR_UP;
      end else if (ev_s[KEY_DOWN]) begin
        ev_dir_s = DIR_DOWN;
      end else if (ev_s[KEY_LEFT]) begin
        ev_dir_s = DIR_LEFT;
      end else if (ev_s[KEY_RIGHT]) begin
        ev_dir_s = DIR_RIGHT;
      end else begin
        has_ev_s = 1'b0;
        ev_dir_s = DIR_UP;
      end
    end

    // Circular-buffer index arithmetic for the newest entry and the next free slot.
    always_comb begin
      tail_i = int'(head_q) + int'(cnt_q) - 1;
      wr_i   = int'(head_q) + int'(cnt_q);
      if (tail_i >= QUEUE_DEPTH) begin
        tail_i = tail_i - QUEUE_DEPTH;
      end else if (tail_i < 0) begin
        tail_i = 0;
      end else begin
        tail_i = tail_i;
      end
      if (wr_i >= QUEUE_DEPTH) begin
        wr_i = wr_i - QUEUE_DEPTH;
      end else begin
        wr_i = wr_i;
      end
      tail_idx_s = IW'(tail_i);
      wr_idx_s   = IW'(wr_i);
    end

    // Filter against the last requested direction, then push/pop/flush the queue.
    always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      chg_d  = 1'b0;
      ovf_d  = 1'b0;

      full_s    = (cnt_q == CNT_FULL);
      ref_dir_s = (cnt_q == CNT_ZERO) ? dir_q : mem_q[tail_idx_s];
      legal_s   = has_ev_s && (ev_dir_s != ref_dir_s) && (ev_dir_s != opposite(ref_dir_s));
      pop_s     = move_tick && (cnt_q != CNT_ZERO);
      push_s    = legal_s && (!full_s || pop_s);

      if (clear) begin
        head_d = IDX_ZERO;
        cnt_d  = CNT_ZERO;
        dir_d  = INIT_DIR;
      end else begin
        ovf_d = legal_s && full_s && !pop_s;
        if (pop_s) begin
          dir_d  = mem_q[head_q];
          chg_d  = (mem_q[head_q] != dir_q);
          head_d = (head_q == IDX_LAST) ? IDX_ZERO : head_q + IDX_ONE;
        end else begin
          head_d = head_q;
        end
        // A push into a full queue lands in the slot the pop is vacating.
        if (push_s) begin
          mem_d[wr_idx_s] = ev_dir_s;
        end else begin
          mem_d = mem_q;
        end
        case ({push_s, pop_s})
          2'b10:   cnt_d = cnt_q + CNT_ONE;
          2'b01:   cnt_d = cnt_q - CNT_ONE;
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // Queue storage, committed direction and output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          mem_q[i] <= INIT_DIR;
        end
        head_q <= IDX_ZERO;
        cnt_q  <= CNT_ZERO;
        dir_q  <= INIT_DIR;
        chg_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        mem_q  <= mem_d;
        head_q <= head_d;
        cnt_q  <= cnt_d;
        dir_q  <= dir_d;
        chg_q  <= chg_d;
        ovf_q  <= ovf_d;
      end
    end

    assign dir_out[2*p +: 2] = dir_q;
    assign dir_changed[p]    = chg_q;
    assign overflow[p]       = ovf_q;
    // Plain OR of the debounce state flops so the lock tracks them without delay.
    assign key_lock[p]       = |held_s[4*p +: 4];
  end

endmodule

// File: doc/snake_dir_queue.md
# snake_dir_queue

Per-player direction input block for the Snake game logic. Each player's four active-low buttons are synchronised, debounced and reduced to single press events. Legal direction changes are queued and committed one per `move_tick`, so quick multi-key turns between game steps are kept in order rather than lost. Illegal 180° reversals are filtered out. The block sits between the board buttons and the snake movement/position logic, with one instance of the player channel per player.

## Interface
- `NUM_PLAYERS`, default 1: number of independent player channels.
- `QUEUE_DEPTH`, default 2: direction entries buffered per player (≥1, power of two not required).
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples needed before a key state changes (≥1).
- `INIT_DIR`, default `DIR_LEFT`: direction loaded at reset and on `clear`.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `keys` in 4*NUM_PLAYERS: raw buttons, active-low. Per player p, bits [4p+3:4p] are {left, up, down, right}.
- `move_tick` in 1: one-cycle pulse from the game timer; commits the next queued direction.
- `clear` in 1: synchronous flush of all queues; `dir_out` returns to `INIT_DIR`.
- `dir_out` out 2*NUM_PLAYERS: committed direction per player (`dir_t`).
- `dir_changed` out NUM_PLAYERS: one-cycle pulse, cycle after a tick that changed `dir_out`.
- `key_lock` out NUM_PLAYERS: high while any debounced key of the player is held.
- `overflow` out NUM_PLAYERS: one-cycle pulse when a legal press was dropped because the queue was full.

## Operation
- Encoding `dir_t`: UP=0, DOWN=1, LEFT=2, RIGHT=3. `opposite(d)` flips bit 0.
- Each key passes through a 2-flop synchroniser, then a saturating counter. The debounced state flips only after `DEBOUNCE_CYCLES` consecutive samples that differ from it.
- A press event is a debounced released→pressed transition. Holding a key produces exactly one event.
- If keys are pressed in the same cycle, priority is up > down > left > right. Lower-priority simultaneous events are discarded.
- The reference direction is the tail queue entry, or `dir_out` when the queue is empty.
- An event equal to the reference, or equal to `opposite(reference)`, is dropped silently. Otherwise it is pushed.
- Push with the queue full (and no pop that cycle): the event is dropped and `overflow` pulses.
- `move_tick` with the queue non-empty: pop the head into `dir_out`. With the queue empty: `dir_out` holds.
- Push and pop in the same cycle both succeed, including when the queue is full.
- `clear` has priority over push, pop and tick. It empties the queue, loads `INIT_DIR`, and asserts no `dir_changed` or `overflow`.
- Channels are fully independent; a tick applies to all players in the same cycle.

## Timing
- Reset values: `dir_out`=`INIT_DIR` for every player; `dir_changed`, `key_lock`, `overflow`=0; queues empty; synchronisers and counters cleared to the released state (1 = released).
- Latency from a raw key going low (held) to the queue push: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge register) cycles.
- Push latency at defaults is 7 cycles. The entry is visible to a tick one cycle after the push.
- Tick to `dir_out` update: 1 cycle (registered on the tick edge). `dir_changed` is asserted in that same following cycle.
- `key_lock` follows the debounced state with zero extra cycles.
- Reset deasserted mid-debounce or mid-queue: all state is lost and no stale event is emitted after release.

## Structure
- Package `snake_pkg` holds:
  - `dir_t`, `DIR_UP`/`DIR_DOWN`/`DIR_LEFT`/`DIR_RIGHT`
  - the `opposite()` function
  - key bit-index constants `KEY_LEFT=3`, `KEY_UP=2`, `KEY_DOWN=1`, `KEY_RIGHT=0`
- Sub-module `snake_key_debounce` (synchroniser + counter + press edge, one key) is instantiated 4*NUM_PLAYERS times.
- The queue and filter are a generate loop per player in the top level.

## Test plan
- Reset with `INIT_DIR`=LEFT, no keys → `dir_out`=2 and all pulses 0. Assert reset mid-queue → queue empty, `dir_out`=2 immediately.
- Up held 10 cycles, then tick → push at cycle 7, `dir_out`=0 on the cycle after the tick, `dir_changed` one pulse.
- Glitches: up low for 3 cycles (< `DEBOUNCE_CYCLES`), three times → no push, `key_lock` stays 0.
- From LEFT: press up, then right, then tick, tick → `dir_out` UP then RIGHT. Pressing right while LEFT with an empty queue → dropped, no overflow.
- `QUEUE_DEPTH`=2, from LEFT: press up, left, down with no tick → third press dropped and `overflow` pulses once. Repeat with a tick coinciding with the third push → no overflow, queue holds {LEFT, DOWN}.
- `NUM_PLAYERS`=2: simultaneous up+right on player 0 and down on player 1, then tick → `dir_out`={DOWN, UP}. Then `clear` → both channels return to LEFT.
